// File: rtl/conv_pool_stage.sv
// conv_pool_stage: 2x2 max-pool of a conv result window, one compare per cycle.
// Optional CONV_POOL_AVG_EN adds a rounded mean output (out_avg).
module conv_pool_stage #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] o00,
  input  logic [DATA_W-1:0] o01,
  input  logic [DATA_W-1:0] o10,
  input  logic [DATA_W-1:0] o11,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_max,
  output logic [1:0]        out_idx,
  output logic [CNT_W-1:0]  frame_cnt
`ifdef CONV_POOL_AVG_EN
  ,
  output logic [DATA_W-1:0] out_avg
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    OUT
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [DATA_W-1:0] r_elem [4];
  logic [DATA_W-1:0] r_max;
  logic [1:0]        r_idx;
  logic [1:0]        r_step;
  logic [DATA_W-1:0] r_out_max;
  logic [1:0]        r_out_idx;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_accept;
  logic              w_hand;
  logic              w_last;
  logic              w_gt;
  logic [DATA_W-1:0] w_cur;
  logic [DATA_W-1:0] w_new_max;
  logic [1:0]        w_new_idx;

  assign w_cur     = r_elem[r_step];
  assign w_gt      = w_cur > r_max;
  assign w_new_max = w_gt ? w_cur : r_max;
  assign w_new_idx = w_gt ? r_step : r_idx;
  assign w_last    = (r_state == SCAN) && (r_step == 2'd3);
  assign w_accept  = in_valid && in_ready;
  assign w_hand    = out_valid && out_ready;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = SCAN;
      end
      SCAN: begin
        if (r_step == 2'd3) w_next = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        if (out_ready) w_next = in_valid ? SCAN : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) r_elem[i] <= '0;
      r_max     <= '0;
      r_idx     <= '0;
      r_step    <= '0;
      r_out_max <= '0;
      r_out_idx <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_accept) begin
        r_elem[0] <= o00;
        r_elem[1] <= o01;
        r_elem[2] <= o10;
        r_elem[3] <= o11;
        r_max     <= o00;
        r_idx     <= 2'd0;
        r_step    <= 2'd1;
      end else if (r_state == SCAN) begin
        // strict greater-than keeps the lower index on ties
        r_max  <= w_new_max;
        r_idx  <= w_new_idx;
        r_step <= r_step + 2'd1;
      end
      if (w_last) begin
        r_out_max <= w_new_max;
        r_out_idx <= w_new_idx;
      end
      if (w_hand && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign out_max   = r_out_max;
  assign out_idx   = r_out_idx;
  assign frame_cnt = r_cnt;

`ifdef CONV_POOL_AVG_EN
  logic [DATA_W+1:0] r_acc;
  logic [DATA_W+1:0] w_sum;
  logic [DATA_W-1:0] r_out_avg;

  assign w_sum = r_acc + {2'b00, w_cur};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc     <= '0;
      r_out_avg <= '0;
    end else begin
      if (w_accept)               r_acc <= {2'b00, o00};
      else if (r_state == SCAN)   r_acc <= w_sum;
      // round half up: (sum + 2) / 4
      if (w_last)
        r_out_avg <= DATA_W'((w_sum + (DATA_W+2)'(2)) >> 2);
    end
  end

  assign out_avg = r_out_avg;
`endif

endmodule

// File: tb/tb_conv_pool_stage.sv
// tb_conv_pool_stage: directed + random windows against a max-pool model.
// Second instance runs with CNT_W=2 to exercise counter saturation.
module tb_conv_pool_stage;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [DW-1:0] o00, o01, o10, o11;

  logic          in_ready, out_valid;
  logic [DW-1:0] out_max;
  logic [1:0]    out_idx;
  logic [15:0]   frame_cnt;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_max;
  logic [1:0]    s_out_idx;
  logic [1:0]    s_frame_cnt;

`ifdef CONV_POOL_AVG_EN
  logic [DW-1:0] out_avg;
  logic [DW-1:0] s_out_avg;
`endif

  conv_pool_stage #(.DATA_W(DW), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .o00(o00), .o01(o01), .o10(o10), .o11(o11),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_max(out_max), .out_idx(out_idx),
    .frame_cnt(frame_cnt)
`ifdef CONV_POOL_AVG_EN
    , .out_avg(out_avg)
`endif
  );

  conv_pool_stage #(.DATA_W(DW), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(s_in_ready),
    .o00(o00), .o01(o01), .o10(o10), .o11(o11),
    .out_valid(s_out_valid), .out_ready(out_ready),
    .out_max(s_out_max), .out_idx(s_out_idx),
    .frame_cnt(s_frame_cnt)
`ifdef CONV_POOL_AVG_EN
    , .out_avg(s_out_avg)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cnt_m = 0;
  int sat_m = 0;
  logic [DW-1:0] win [4];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // reference: max value, lowest index holding it, rounded mean
  task automatic ref_pool(input logic [DW-1:0] e [4],
                          output logic [DW-1:0] m,
                          output logic [1:0] ix,
                          output logic [DW-1:0] av);
    int mx, sum, first;
    mx = 0;
    sum = 0;
    for (int i = 0; i < 4; i++) begin
      if (int'(e[i]) > mx) mx = int'(e[i]);
      sum += int'(e[i]);
    end
    first = 0;
    for (int i = 3; i >= 0; i--)
      if (int'(e[i]) == mx) first = i;
    m  = DW'(mx);
    ix = 2'(first);
    av = DW'((sum + 2) / 4);
  endtask

  task automatic drive_win();
    o00 = win[0];
    o01 = win[1];
    o10 = win[2];
    o11 = win[3];
  endtask

  task automatic scramble();
    o00 = DW'($urandom);
    o01 = DW'($urandom);
    o10 = DW'($urandom);
    o11 = DW'($urandom);
  endtask

  task automatic count_handoff();
    cnt_m++;
    if (sat_m < 3) sat_m++;
    chk("frame_cnt", 32'(frame_cnt), 32'(cnt_m));
    chk("sat_cnt", 32'(s_frame_cnt), 32'(sat_m));
  endtask

  task automatic check_result(input logic [DW-1:0] e [4],
                              input string tag);
    logic [DW-1:0] m, av;
    logic [1:0] ix;
    ref_pool(e, m, ix, av);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_max"}, 32'(out_max), 32'(m));
    chk({tag, "_idx"}, 32'(out_idx), 32'(ix));
`ifdef CONV_POOL_AVG_EN
    chk({tag, "_avg"}, 32'(out_avg), 32'(av));
`else
    if (av > m) chk({tag, "_avg_bound"}, 32'(av), 32'(m));
`endif
  endtask

  task automatic run_window(input string tag);
    logic [DW-1:0] snap [4];
    snap = win;
    chk({tag, "_rdy"}, 32'(in_ready), 32'd1);
    drive_win();
    in_valid  = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    scramble();
    tick();
    chk({tag, "_lat1"}, 32'(out_valid), 32'd0);
    tick();
    chk({tag, "_lat2"}, 32'(out_valid), 32'd0);
    tick();
    check_result(snap, tag);
    tick();
    count_handoff();
    chk({tag, "_done"}, 32'(out_valid), 32'd0);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] wa [4];
    logic [DW-1:0] wb [4];
    logic [DW-1:0] ma, avg_a;
    logic [1:0] ia;

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    scramble();
    tick();
    tick();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_max", 32'(out_max), 32'd0);
    chk("rst_idx", 32'(out_idx), 32'd0);
    chk("rst_cnt", 32'(frame_cnt), 32'd0);
    chk("rst_scnt", 32'(s_frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    win = '{8'd67, 8'd74, 8'd34, 8'd59};
    run_window("nominal");
    win = '{8'd5, 8'd9, 8'd9, 8'd2};
    run_window("tie");
    win = '{8'd0, 8'd0, 8'd0, 8'd200};
    run_window("last");
    win = '{8'd0, 8'd0, 8'd0, 8'd0};
    run_window("zero");
    win = '{8'd255, 8'd255, 8'd255, 8'd255};
    run_window("full");

    // backpressure with a second window waiting
    wa = '{8'd12, 8'd40, 8'd40, 8'd99};
    wb = '{8'd180, 8'd3, 8'd181, 8'd7};
    ref_pool(wa, ma, ia, avg_a);
    win = wa;
    drive_win();
    in_valid = 1'b1;
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    scramble();
    tick();
    tick();
    tick();
    win = wb;
    drive_win();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_max", 32'(out_max), 32'(ma));
      chk("bp_idx", 32'(out_idx), 32'(ia));
      chk("bp_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_ready_up", 32'(in_ready), 32'd1);
    tick();
    count_handoff();
    in_valid = 1'b0;
    scramble();
    tick();
    tick();
    chk("bp_lat", 32'(out_valid), 32'd0);
    tick();
    check_result(wb, "bp2");
    tick();
    count_handoff();
    out_ready = 1'b0;

    // reset during scan step 2
    win = '{8'd1, 8'd2, 8'd3, 8'd4};
    drive_win();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    rst = 1'b0;
    #1;
    cnt_m = 0;
    sat_m = 0;
    chk("mid_valid", 32'(out_valid), 32'd0);
    chk("mid_ready", 32'(in_ready), 32'd1);
    chk("mid_cnt", 32'(frame_cnt), 32'd0);
    chk("mid_scnt", 32'(s_frame_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    win = '{8'd10, 8'd77, 8'd76, 8'd77};
    run_window("post_rst");

    // random windows; small ranges on half of them provoke ties
    for (int n = 0; n < 30; n++) begin
      for (int k = 0; k < 4; k++)
        win[k] = (n % 2 == 0) ? DW'($urandom_range(0, 3))
                              : DW'($urandom);
      run_window("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_pool_stage.md
Name: conv_pool_stage

Overview:
- Downstream consumer of the 2x2 convolution result produced by the systolic conv arrays (4x4 input, 3x3 filter, 8-bit outputs o00/o01/o10/o11).
- Captures one 2x2 result window on a valid/ready handshake and max-pools it to a single value plus its argmax index, using a sequential one-compare-per-cycle scan.
- Presents the pooled result on a valid/ready output and counts completed windows.

Parameters:
- DATA_W, 8, width of each conv output element and of out_max.
- CNT_W, 16, width of the completed-window counter frame_cnt.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  upstream result window valid.
- in_ready  output  1  stage can accept a window.
- o00  input  DATA_W  conv output row 0 col 0 (index 0).
- o01  input  DATA_W  conv output row 0 col 1 (index 1).
- o10  input  DATA_W  conv output row 1 col 0 (index 2).
- o11  input  DATA_W  conv output row 1 col 1 (index 3).
- out_valid  output  1  pooled result valid.
- out_ready  input  1  downstream accepts the result.
- out_max  output  DATA_W  maximum of the four elements, unsigned.
- out_idx  output  2  index of the maximum element.
- frame_cnt  output  CNT_W  number of results handed off since reset.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, all element registers=0, out_max=0, out_idx=0, out_valid=0, frame_cnt=0, scan step=0. Reset mid-scan or mid-output aborts the window; no result and no count increment.
- FSM states are IDLE, SCAN and OUT.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid=1 at an edge: latch all four elements, set max=o00, idx=0, step=1, and go to SCAN.
- SCAN:
  - in_ready=0, out_valid=0.
  - Each edge compares element[step] against max. Replace only if strictly greater, so ties keep the lower index.
  - Step advances 1→2→3. After the step-3 compare, go to OUT.
- OUT:
  - out_valid=1; out_max/out_idx stay stable until handshake.
  - On an edge with out_ready=1: frame_cnt increments, then:
    - in_valid=0: go to IDLE.
    - in_valid=1: accept the new window in the same cycle and go to SCAN (load as in IDLE).
  - in_ready=out_ready (combinational) while in OUT.
  - out_ready=0: hold; in_valid is ignored (in_ready=0).
- Latency: window accepted at edge E0 → out_valid high after E3 (3 cycles). Peak throughput is one window per 4 cycles.
- Arithmetic:
  - Compares are unsigned, DATA_W bits.
  - frame_cnt saturates at 2^CNT_W-1 and does not wrap.
  - Input elements are sampled only at accept. Upstream may change them afterwards.
- out_max/out_idx retain their last value in IDLE/SCAN. Only out_valid qualifies them.

Optional Feature:
- Macro: CONV_POOL_AVG_EN.
- Defined:
  - Adds output port out_avg (DATA_W).
  - A DATA_W+2 accumulator is loaded with o00 at accept, and each SCAN step adds element[step].
  - out_avg=(sum+2)>>2 (round-half-up), valid with out_valid, reset value 0.
- Undefined: no out_avg port, no accumulator; all other behaviour identical.

Test Plan:
- Reset check: hold rst=0 for 2 cycles → out_valid=0, in_ready=1, out_max=0, out_idx=0, frame_cnt=0.
- Nominal window {67,74,34,59} (systolic result of the standard 4x4/3x3 vector) with in_valid pulse, out_ready=1:
  - out_valid rises 3 cycles after accept, with out_max=74, out_idx=1.
  - frame_cnt=1 after handoff.
  - With CONV_POOL_AVG_EN: out_avg=59.
- Tie and position: window {5,9,9,2} → out_max=9, out_idx=1. Window {0,0,0,200} → out_idx=3, out_max=200. Window all-zero → out_idx=0.
- Backpressure: out_ready=0 for 10 cycles with in_valid=1 held and a second window waiting:
  - out_valid stays 1, outputs stable, in_ready=0.
  - Raising out_ready: first result handed off and second window accepted on the same edge.
  - Second result 3 cycles later; frame_cnt=2.
- Reset mid-operation: assert rst=0 during SCAN step 2 → immediate IDLE, out_valid=0, frame_cnt unchanged at its reset value 0. The next window processes normally.
- Counter saturation, with CNT_W overridden to 2: push 5 windows → frame_cnt sequence 1,2,3,3,3.
